board_io_ctrl: RTL
==================

// Module: board_io_ctrl
// PURPOSE
//  Parametrised board I/O controller for the Arty-class system tops: synchronises and debounces
//  push buttons and slide switches, reports debounced edges via a sticky event/irq handshake,
//  registers the plain LED bank and drives RGB LEDs with per-colour PWM. Sits between the
//  board pins and the system wrapper, replacing direct pin-to-wrapper wiring.
// PARAMETERS
//  NUM_BUTTONS      4       push-button inputs
//  NUM_SWITCHES     4       slide-switch inputs
//  NUM_LEDS         4       plain LED outputs
//  NUM_RGB          4       RGB LEDs (3 channels each: bit0 R, bit1 G, bit2 B)
//  DEBOUNCE_CYCLES  100000  cycles an input must stay stable before acceptance (>=2)
//  PWM_BITS         8       PWM counter / duty width
// PORTS
//  clk            in   1                    system clock
//  rst            in   1                    reset
//  push_buttons   in   NUM_BUTTONS          raw button pins, asynchronous
//  slide_switches in   NUM_SWITCHES         raw switch pins, asynchronous
//  led_value      in   NUM_LEDS             requested LED state
//  rgb_duty       in   NUM_RGB*3*PWM_BITS   duty per channel, channel k at [k*PWM_BITS +: PWM_BITS]
//  btn_state      out  NUM_BUTTONS          debounced button level
//  btn_press      out  NUM_BUTTONS          1-cycle pulse on debounced 0->1
//  sw_state       out  NUM_SWITCHES         debounced switch level
//  event_flags    out  NUM_BUTTONS+NUM_SWITCHES  sticky changed-bits, switches in upper bits
//  irq            out  1                    high while any event_flags bit set
//  irq_ack        in   1                    clears event_flags sampled this cycle
//  four_leds      out  NUM_LEDS             registered led_value
//  rgb_led        out  NUM_RGB*3            PWM outputs
// BEHAVIOUR
//  - Single clock clk; rst asynchronous, active-high. All outputs and state 0 in reset.
//  - Per input: 2-FF synchroniser -> debounce. cnt clears when sync==stable; else increments;
//    when cnt==DEBOUNCE_CYCLES-1 and sync!=stable, stable<=sync and cnt<=0. Any bounce back
//    clears cnt. Pin change stable from cycle 0 -> state output changes at cycle DEBOUNCE_CYCLES+2.
//  - btn_press high exactly the cycle after btn_state rises; no pulse on release.
//  - event_flags bit sets the cycle a debounced level changes (either direction).
//    irq_ack: next = (flags & ~flags) | new_events, i.e. ack clears all, same-cycle events survive.
//    irq = |event_flags (registered). Ack with no flags set is a no-op.
//  - four_leds <= led_value every cycle (1-cycle latency).
//  - PWM: free-running PWM_BITS counter, wraps all-ones -> 0. Each channel has a shadow duty
//    loaded from rgb_duty only when counter==all-ones (glitch-free update at period boundary).
//    rgb_led[k] = registered (counter < shadow[k]). duty 0 -> constant low; duty max -> high
//    (2^PWM_BITS-1) of every 2^PWM_BITS cycles. Shadows reset to 0.
//  - rst mid-debounce discards partial counts; after release, inputs already high need
//    DEBOUNCE_CYCLES+2 cycles and then raise an event.
// CONFIGURATION
//  BOARD_IO_SW_DEBOUNCE_EN defined: switches use the full debounce path as above.
//  Undefined: switches use only the 2-FF synchroniser (sw_state follows pin after 2 cycles,
//  events per synchronised change); debounce counters for switches not instantiated.
//  Buttons always debounced.
// STRUCTURE
//  - board_io_pkg: channel-index localparams (RGB_R/G/B=0/1/2), debounce counter width
//    function clog2, event_flags bit-layout offsets.
//  - Sub-module io_debounce (sync + counter + stable reg, parameter DEBOUNCE_CYCLES, BYPASS);
//    generate-instantiated per button/switch. PWM and event logic stay in the top module.
// TESTING  (bench uses DEBOUNCE_CYCLES=8, PWM_BITS=4)
//  - Button 0 high with 3 bounces of 4 cycles then steady -> btn_state[0] rises 10 cycles after
//    last edge, btn_press[0] one cycle, event_flags[0]=1, irq=1.
//  - irq_ack in same cycle as switch 2 debounced change -> flags become only bit NUM_BUTTONS+2, irq stays 1.
//  - rgb_duty ch0=0, ch1=15, ch2=5 -> over 16 cycles ch0 never high, ch1 high 15, ch2 high 5.
//  - Change duty ch2 5->9 mid-period -> current period keeps 5 highs, next period 9.
//  - Assert rst at counter=5 of pending debounce with pin held high -> outputs 0 immediately;
//    after release btn_state rises after 10 cycles with event.
//  - Build without BOARD_IO_SW_DEBOUNCE_EN: switch toggle -> sw_state follows in 2 cycles.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O controller: RGB channel indices,
// debounce counter sizing and event_flags bit layout.
package board_io_pkg;

  localparam int unsigned RGB_R  = 0;
  localparam int unsigned RGB_G  = 1;
  localparam int unsigned RGB_B  = 2;
  localparam int unsigned RGB_CH = 3;

  // Buttons occupy the low event bits, switches sit directly above them
  localparam int unsigned EVT_BTN_OFS = 0;

  function automatic int unsigned evt_sw_ofs(input int unsigned num_buttons);
    return num_buttons;
  endfunction

  // Ceiling log2, never below 1 so a counter always has at least one bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/board_io_if.sv
// Pin/wrapper-side bundle for board_io_ctrl; master is the board/system side,
// slave is the controller.
interface board_io_if #(
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned NUM_SWITCHES = 4,
  parameter int unsigned NUM_LEDS     = 4,
  parameter int unsigned NUM_RGB      = 4,
  parameter int unsigned PWM_BITS     = 8
);

  logic [NUM_BUTTONS-1:0]              push_buttons;
  logic [NUM_SWITCHES-1:0]             slide_switches;
  logic [NUM_LEDS-1:0]                 led_value;
  logic [NUM_RGB*3*PWM_BITS-1:0]       rgb_duty;
  logic                                irq_ack;
  logic [NUM_BUTTONS-1:0]              btn_state;
  logic [NUM_BUTTONS-1:0]              btn_press;
  logic [NUM_SWITCHES-1:0]             sw_state;
  logic [NUM_BUTTONS+NUM_SWITCHES-1:0] event_flags;
  logic                                irq;
  logic [NUM_LEDS-1:0]                 four_leds;
  logic [NUM_RGB*3-1:0]                rgb_led;

  modport master (
    output push_buttons, slide_switches, led_value, rgb_duty, irq_ack,
    input  btn_state, btn_press, sw_state, event_flags, irq, four_leds, rgb_led
  );

  modport slave (
    input  push_buttons, slide_switches, led_value, rgb_duty, irq_ack,
    output btn_state, btn_press, sw_state, event_flags, irq, four_leds, rgb_led
  );

endinterface

// File: rtl/io_debounce.sv
// One input channel: 2-FF synchroniser followed by a stability counter. With BYPASS
// set the counter is not built and the synchronised level is reported directly.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter bit          BYPASS          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_state,
  output logic o_change_c
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      // Level changes on the next edge whenever the two sync stages disagree
      assign o_state    = r_sync2;
      assign o_change_c = r_sync1 ^ r_sync2;
    end else begin : g_debounce
      localparam int unsigned    CW      = clog2(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_stable;
      logic          w_expire;

      assign w_expire = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);

      // Any return to the accepted level restarts the stability window
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (w_expire) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign o_state    = r_stable;
      assign o_change_c = w_expire;
    end
  endgenerate

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons/switches with sticky event flags and irq,
// registered LED bank, per-channel RGB PWM. Define BOARD_IO_SW_DEBOUNCE_EN to debounce
// switches; otherwise switches are only synchronised.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned NUM_SWITCHES    = 4,
  parameter int unsigned NUM_LEDS        = 4,
  parameter int unsigned NUM_RGB         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PWM_BITS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  board_io_if.slave  io
);

  localparam int unsigned NUM_EVT = NUM_BUTTONS + NUM_SWITCHES;
  localparam int unsigned NUM_CH  = NUM_RGB * RGB_CH;
  localparam int unsigned SW_OFS  = evt_sw_ofs(NUM_BUTTONS);

`ifdef BOARD_IO_SW_DEBOUNCE_EN
  localparam bit SW_BYPASS = 1'b0;
`else
  localparam bit SW_BYPASS = 1'b1;
`endif

  logic [NUM_BUTTONS-1:0]     w_btn_state;
  logic [NUM_BUTTONS-1:0]     w_btn_chg;
  logic [NUM_SWITCHES-1:0]    w_sw_state;
  logic [NUM_SWITCHES-1:0]    w_sw_chg;
  logic [NUM_EVT-1:0]         w_new_evt;
  logic [NUM_EVT-1:0]         w_flags_next;
  logic [NUM_CH-1:0]          w_rgb_next;

  logic [NUM_BUTTONS-1:0]     r_btn_prev;
  logic [NUM_BUTTONS-1:0]     r_btn_press;
  logic [NUM_EVT-1:0]         r_flags;
  logic                       r_irq;
  logic [NUM_LEDS-1:0]        r_leds;
  logic [PWM_BITS-1:0]        r_pwm_cnt;
  logic [NUM_CH*PWM_BITS-1:0] r_shadow;
  logic [NUM_CH-1:0]          r_rgb;

  generate
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BYPASS          (1'b0)
      ) u_btn (
        .clk        (clk),
        .rst        (rst),
        .i_pin      (io.push_buttons[i]),
        .o_state    (w_btn_state[i]),
        .o_change_c (w_btn_chg[i])
      );
    end
    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
      io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BYPASS          (SW_BYPASS)
      ) u_sw (
        .clk        (clk),
        .rst        (rst),
        .i_pin      (io.slide_switches[i]),
        .o_state    (w_sw_state[i]),
        .o_change_c (w_sw_chg[i])
      );
    end
  endgenerate

  // Ack clears everything sampled this cycle; changes landing on the same edge survive
  always_comb begin
    w_new_evt                            = '0;
    w_new_evt[EVT_BTN_OFS +: NUM_BUTTONS] = w_btn_chg;
    w_new_evt[SW_OFS +: NUM_SWITCHES]     = w_sw_chg;
    w_flags_next = (io.irq_ack ? '0 : r_flags) | w_new_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_prev  <= '0;
      r_btn_press <= '0;
      r_flags     <= '0;
      r_irq       <= 1'b0;
      r_leds      <= '0;
    end else begin
      r_btn_prev  <= w_btn_state;
      r_btn_press <= w_btn_state & ~r_btn_prev;
      r_flags     <= w_flags_next;
      r_irq       <= |w_flags_next;
      r_leds      <= io.led_value;
    end
  end

  always_comb begin
    w_rgb_next = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_rgb_next[k] = r_pwm_cnt < r_shadow[k*PWM_BITS +: PWM_BITS];
    end
  end

  // Duty shadows reload only as the counter wraps so a period is never cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_shadow  <= '0;
      r_rgb     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (&r_pwm_cnt) r_shadow <= io.rgb_duty;
      r_rgb <= w_rgb_next;
    end
  end

  assign io.btn_state   = w_btn_state;
  assign io.btn_press   = r_btn_press;
  assign io.sw_state    = w_sw_state;
  assign io.event_flags = r_flags;
  assign io.irq         = r_irq;
  assign io.four_leds   = r_leds;
  assign io.rgb_led     = r_rgb;

endmodule
